regfile_arbiter: RTL and testbench

Shares the single-port 8×4-bit register file between two requesters: requester 0 is the core execute sequencer, requester 1 is the debug/scan port. Each cycle the block arbitrates one access, drives the register file's address, write-data and write-enable, and returns a registered acknowledge with the read data. A lock mechanism lets one requester own the file for multi-cycle read-modify-write sequences. A timeout counter breaks locks held by an idle owner.

---
 rtl/regfile_arbiter.sv | 92 +++++++++
 tb/tb_regfile_arbiter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: two-requester arbiter with lock/timeout for a single-port 8xWIDTH register file.
// Define REGFILE_ARB_RR_EN for round-robin tie-breaking; fixed R0 priority otherwise.
module regfile_arbiter #(
    parameter int WIDTH    = 4,
    parameter int LOCK_TMO = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_req,
    input  logic             r0_wen,
    input  logic [2:0]       r0_addr,
    input  logic [WIDTH-1:0] r0_wdata,
    input  logic             r0_lock,
    input  logic             r0_hold,
    output logic             r0_gnt,
    output logic             r0_ack,
    output logic [WIDTH-1:0] r0_rdata,
    input  logic             r1_req,
    input  logic             r1_wen,
    input  logic [2:0]       r1_addr,
    input  logic [WIDTH-1:0] r1_wdata,
    input  logic             r1_lock,
    input  logic             r1_hold,
    output logic             r1_gnt,
    output logic             r1_ack,
    output logic [WIDTH-1:0] r1_rdata,
    output logic [2:0]       rf_addr,
    output logic [WIDTH-1:0] rf_wdata,
    output logic             rf_wen,
    input  logic [WIDTH-1:0] rf_rdata,
    output logic             lock_err
);
    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
    localparam logic [7:0] TMO = 8'(LOCK_TMO);
    state_t     state;
    logic [7:0] cnt;
    logic       ack0, ack1, v0, v1, fav1;
    logic       own_req, own_gnt, own_lock;
    // hold is an external stall that keeps a requester from being granted
    assign v0 = r0_req & ~r0_hold & ~rst & (state != LOCK1);
    assign v1 = r1_req & ~r1_hold & ~rst & (state != LOCK0);
`ifdef REGFILE_ARB_RR_EN
    logic ptr;
    always_ff @(posedge clk) begin
        if (rst) ptr <= 1'b0;
        else if (r0_gnt | r1_gnt) ptr <= r0_gnt;
    end
    assign fav1 = ptr;
`else
    assign fav1 = 1'b0;
`endif
    assign r0_gnt   = v0 & (~v1 | ~fav1);
    assign r1_gnt   = v1 & ~r0_gnt;
    assign rf_addr  = r1_gnt ? r1_addr : r0_addr;
    assign rf_wdata = r1_gnt ? r1_wdata : r0_wdata;
    assign rf_wen   = (r0_gnt & r0_wen) | (r1_gnt & r1_wen);
    // a pending ack is dropped as soon as reset is seen
    assign r0_ack   = ack0 & ~rst;
    assign r1_ack   = ack1 & ~rst;
    assign own_req  = (state == LOCK1) ? r1_req : r0_req;
    assign own_gnt  = (state == LOCK1) ? r1_gnt : r0_gnt;
    assign own_lock = (state == LOCK1) ? r1_lock : r0_lock;
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 8'd0;
            lock_err <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            r0_rdata <= '0;
            r1_rdata <= '0;
        end else begin
            ack0     <= r0_gnt;
            ack1     <= r1_gnt;
            lock_err <= 1'b0;
            cnt      <= 8'd0;
            if (r0_gnt) r0_rdata <= rf_rdata;
            if (r1_gnt) r1_rdata <= rf_rdata;
            if (state == IDLE)
                state <= (r0_gnt & r0_lock) ? LOCK0 : (r1_gnt & r1_lock) ? LOCK1 : IDLE;
            else if (!own_req)
                state <= IDLE;
            else if (own_gnt)
                state <= own_lock ? state : IDLE;
            else if (cnt + 8'd1 == TMO) begin
                state    <= IDLE;
                lock_err <= 1'b1;
            end else
                cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed checks of arbitration, lock, timeout and reset with a behavioural register file.
module tb_regfile_arbiter;
    logic       clk = 0, rst = 1;
    logic       r0_req = 0, r0_wen = 0, r0_lock = 0, r0_hold = 0;
    logic       r1_req = 0, r1_wen = 0, r1_lock = 0, r1_hold = 0;
    logic [2:0] r0_addr = 0, r1_addr = 0, rf_addr;
    logic [3:0] r0_wdata = 0, r1_wdata = 0, r0_rdata, r1_rdata, rf_wdata, rf_rdata;
    logic       r0_gnt, r1_gnt, r0_ack, r1_ack, rf_wen, lock_err;
    logic [3:0] mem [8];
    int         pass = 0, total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 8; i++) mem[i] <= 4'h0;
        else if (rf_wen && rf_addr != 3'd1) mem[rf_addr] <= rf_wdata;
    end
    assign rf_rdata = mem[rf_addr];

    regfile_arbiter #(.WIDTH(4), .LOCK_TMO(3)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_wen(r0_wen), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_lock(r0_lock), .r0_hold(r0_hold), .r0_gnt(r0_gnt), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_wen(r1_wen), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_lock(r1_lock), .r1_hold(r1_hold), .r1_gnt(r1_gnt), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_wen(rf_wen), .rf_rdata(rf_rdata),
        .lock_err(lock_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet;
        r0_req = 0; r0_wen = 0; r0_lock = 0; r0_hold = 0;
        r1_req = 0; r1_wen = 0; r1_lock = 0; r1_hold = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        tick();
        r0_req = 1; r0_wen = 1; r0_addr = 3'd4; r0_wdata = 4'h9; r1_req = 1;
        #1;
        total++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) $display("FAIL rst_gnt: got %b%b want 00", r0_gnt, r1_gnt); else pass++;
        total++; if (rf_wen !== 1'b0) $display("FAIL rst_wen: got %b want 0", rf_wen); else pass++;
        tick();
        quiet();
        rst = 0;
        #1;
        total++; if (r0_ack !== 1'b0 || r1_ack !== 1'b0 || lock_err !== 1'b0) $display("FAIL rst_ack: got %b%b%b want 000", r0_ack, r1_ack, lock_err); else pass++;
        total++; if (r0_rdata !== 4'h0 || r1_rdata !== 4'h0) $display("FAIL rst_rdata: got %h %h want 0 0", r0_rdata, r1_rdata); else pass++;
    endtask

    task automatic test_read;
        r0_req = 1; r0_addr = 3'd3;
        #1;
        total++; if (r0_gnt !== 1'b1) $display("FAIL read_gnt: got %b want 1", r0_gnt); else pass++;
        tick();
        quiet();
        total++; if (r0_ack !== 1'b1 || r0_rdata !== 4'h0) $display("FAIL read_ack: got ack=%b data=%h want 1 0", r0_ack, r0_rdata); else pass++;
        tick();
        total++; if (r0_ack !== 1'b0) $display("FAIL read_ack_pulse: got %b want 0", r0_ack); else pass++;
    endtask

    task automatic test_write;
        r1_req = 1; r1_wen = 1; r1_addr = 3'd5; r1_wdata = 4'hA;
        #1;
        total++; if (rf_wen !== 1'b1 || r1_gnt !== 1'b1 || rf_addr !== 3'd5 || rf_wdata !== 4'hA) $display("FAIL write_drive: got wen=%b gnt=%b addr=%0d data=%h want 1 1 5 a", rf_wen, r1_gnt, rf_addr, rf_wdata); else pass++;
        tick();
        quiet();
        r0_req = 1; r0_addr = 3'd5;
        #1;
        total++; if (r1_ack !== 1'b1 || r1_rdata !== 4'h0) $display("FAIL write_prevalue: got ack=%b data=%h want 1 0", r1_ack, r1_rdata); else pass++;
        tick();
        quiet();
        total++; if (r0_rdata !== 4'hA) $display("FAIL write_readback: got %h want a", r0_rdata); else pass++;
        r0_req = 1; r0_wen = 1; r0_addr = 3'd1; r0_wdata = 4'hF;
        #1;
        total++; if (rf_wen !== 1'b1 || rf_addr !== 3'd1) $display("FAIL ro_addr_drive: got wen=%b addr=%0d want 1 1", rf_wen, rf_addr); else pass++;
        tick();
        r0_wen = 0;
        tick();
        quiet();
        total++; if (r0_rdata !== 4'h0 || r0_ack !== 1'b1) $display("FAIL ro_addr_read: got data=%h ack=%b want 0 1", r0_rdata, r0_ack); else pass++;
    endtask

    task automatic test_back_to_back;
        logic e0;
        r1_req = 1; r1_addr = 3'd0;
        tick();
        r0_req = 1; r0_addr = 3'd5; r1_addr = 3'd3;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef REGFILE_ARB_RR_EN
            e0 = (i % 2 == 0);
`else
            e0 = 1'b1;
`endif
            total++; if (r0_gnt !== e0 || r1_gnt !== !e0) $display("FAIL tie_gnt%0d: got %b%b want %b%b", i, r0_gnt, r1_gnt, e0, !e0); else pass++;
            tick();
            total++; if (r0_ack !== e0 || (e0 && r0_rdata !== 4'hA)) $display("FAIL tie_ack%0d: got ack=%b data=%h want %b a", i, r0_ack, r0_rdata, e0); else pass++;
        end
        r0_req = 0;
        #1;
        total++; if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) $display("FAIL tie_fifth: got %b%b want 01", r0_gnt, r1_gnt); else pass++;
        tick();
        quiet();
        tick();
    endtask

    task automatic test_lock;
        r1_req = 1; r1_addr = 3'd2; r1_lock = 1;
        #1;
        total++; if (r1_gnt !== 1'b1) $display("FAIL lock_take: got %b want 1", r1_gnt); else pass++;
        tick();
        r0_req = 1; r0_addr = 3'd2;
        #1;
        total++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b1) $display("FAIL lock_hold: got %b%b want 01", r0_gnt, r1_gnt); else pass++;
        tick();
        r1_wen = 1; r1_wdata = 4'h7; r1_lock = 0;
        #1;
        total++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b1 || rf_wen !== 1'b1) $display("FAIL lock_release_wr: got %b%b wen=%b want 01 1", r0_gnt, r1_gnt, rf_wen); else pass++;
        tick();
        r1_req = 0; r1_wen = 0;
        #1;
        total++; if (r0_gnt !== 1'b1) $display("FAIL lock_after: got %b want 1", r0_gnt); else pass++;
        tick();
        quiet();
        total++; if (r0_rdata !== 4'h7 || lock_err !== 1'b0) $display("FAIL lock_data: got %h err=%b want 7 0", r0_rdata, lock_err); else pass++;
    endtask

    task automatic test_timeout;
        r0_req = 1; r0_addr = 3'd3; r0_lock = 1;
        #1;
        total++; if (r0_gnt !== 1'b1) $display("FAIL tmo_take: got %b want 1", r0_gnt); else pass++;
        tick();
        r0_hold = 1; r1_req = 1; r1_addr = 3'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || lock_err !== 1'b0) $display("FAIL tmo_wait%0d: got %b%b err=%b want 00 0", i, r0_gnt, r1_gnt, lock_err); else pass++;
            tick();
        end
        total++; if (lock_err !== 1'b1 || r1_gnt !== 1'b1) $display("FAIL tmo_err: got err=%b gnt1=%b want 1 1", lock_err, r1_gnt); else pass++;
        tick();
        quiet();
        total++; if (lock_err !== 1'b0 || r1_rdata !== 4'hA) $display("FAIL tmo_pulse: got err=%b data=%h want 0 a", lock_err, r1_rdata); else pass++;
        r0_req = 1; r0_lock = 1;
        tick();
        r0_req = 0; r1_req = 1;
        #1;
        total++; if (r1_gnt !== 1'b0) $display("FAIL rel_block: got %b want 0", r1_gnt); else pass++;
        tick();
        total++; if (r1_gnt !== 1'b1 || lock_err !== 1'b0) $display("FAIL rel_req0: got gnt1=%b err=%b want 1 0", r1_gnt, lock_err); else pass++;
        tick();
        quiet();
        tick();
    endtask

    task automatic test_reset_mid;
        r0_req = 1; r0_addr = 3'd5; r0_lock = 1;
        tick();
        quiet();
        rst = 1;
        #1;
        total++; if (r0_ack !== 1'b0) $display("FAIL rstmid_ack: got %b want 0", r0_ack); else pass++;
        tick();
        rst = 0;
        r1_req = 1; r1_addr = 3'd0;
        #1;
        total++; if (r0_ack !== 1'b0 || r0_rdata !== 4'h0) $display("FAIL rstmid_state: got ack=%b data=%h want 0 0", r0_ack, r0_rdata); else pass++;
        total++; if (r1_gnt !== 1'b1) $display("FAIL rstmid_unlock: got %b want 1", r1_gnt); else pass++;
        tick();
        quiet();
        total++; if (lock_err !== 1'b0) $display("FAIL rstmid_err: got %b want 0", lock_err); else pass++;
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_lock();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
